ternary_mvm_seq: RTL and testbench
==================================

# ternary_mvm_seq

Sequencer for the 14×7 ternary matrix-vector multiply datapath. It accepts one step at a time: two input activations plus their two weight columns, with a valid/ready handshake. It drives the datapath's step index, weight and vector buses, and walks the datapath's output index to collect the 7 results into a local buffer. It then streams the results out one byte per handshake, so the datapath itself is never stalled.

## Interface
- `InLen`, default 14: input vector length; a job has `InLen/2` steps (7); must be even.
- `OutLen`, default 7: output vector length; must be ≤ 8 (3-bit index).
- `BitWidth`, default 8: activation and result width, two's complement.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `start` in 1: begin a job; sampled only in IDLE.
- `busy` out 1: high in every state except IDLE.
- `done` out 1: one-cycle pulse after the last output handshake.
- `step_w` in 2*InLen: weights for this step. Bits [2c+1:2c] apply to vector byte 0, output c. Bits [InLen+2c+1:InLen+2c] apply to vector byte 1, output c.
- `step_vec` in 2*BitWidth: byte 0 in [BitWidth-1:0], byte 1 in the upper half.
- `step_valid` in 1, `step_ready` out 1: step handshake.
- `mult_row` out 3: datapath step/output index.
- `mult_en` out 1: equals `busy`.
- `mult_w` out 2*InLen, `mult_vec` out 2*BitWidth: datapath operand buses.
- `mult_vecout` in BitWidth: datapath result for index `mult_row`.
- `out_data` out BitWidth, `out_valid` out 1, `out_ready` in 1, `out_last` out 1: result stream.

## Operation
- Weight codes: 01 = +1, 11 = −1, 00 and 10 = 0. The datapath accumulates modulo 2^BitWidth.
- Datapath contract:
  - At each rising edge with `mult_row` = 0, the accumulator is reloaded with this cycle's contribution.
  - At each edge with any other index, the contribution is added to the accumulator.
  - The result register captures the accumulator whenever `mult_row` = 0.
  - `mult_vecout` shows result byte `mult_row`.
- States:
  - IDLE: `step_ready`=0, `mult_row`=0, `mult_w`=0, `mult_vec`=0. `start`=1 → ACCUM, with `k`=0.
  - ACCUM: `step_ready`=1, `mult_row`=`k`.
    - If `step_valid`: `mult_w`=`step_w` and `mult_vec`=`step_vec` (combinational pass-through). The step is accepted and `k` increments.
    - If not `step_valid`: `mult_w`=0 and `mult_vec`=0. This adds zero, or clears harmlessly when `k`=0.
    - Accepting step `InLen/2`−1 → DRAIN, with `j`=0.
  - DRAIN: `step_ready`=0, `mult_w`=0, `mult_vec`=0, `mult_row`=`j`. At the end of each cycle `buf[j]`<=`mult_vecout` and `j` increments. After `j`=`OutLen`−1 → STREAM, with `p`=0.
    - The `j`=0 cycle makes the result register capture the final sums. From then on the result register holds, because `mult_row` stays nonzero.
    - DRAIN never stalls.
  - STREAM: `out_valid`=1, `out_data`=`buf[p]`, `out_last`=(`p`==`OutLen`−1). On `out_ready`, `p` increments. The handshake with `out_last` high → IDLE, with `done`=1 for one cycle.
- `start` outside IDLE is ignored. `step_valid` outside ACCUM is ignored; no step is accepted.
- `rst` mid-job: abandon the job, return to IDLE, and clear `k`, `j`, `p` and the buffer.

## Timing
- Reset values:
  - `busy`=0, `done`=0.
  - `step_ready`=0, `out_valid`=0, `out_last`=0, `out_data`=0.
  - `mult_row`=0, `mult_en`=0, `mult_w`=0, `mult_vec`=0.
  - State IDLE.
- `start` at cycle t: ACCUM from t+1, so `step_ready` is high at t+1.
- Step accept is zero-latency: the datapath consumes the step at the same edge as the handshake.
- Unstalled job: 7 ACCUM cycles + `OutLen` DRAIN cycles. The first `out_valid` comes `InLen/2`+`OutLen`+1 = 15 cycles after `start`.
- With `out_ready` held high, one byte leaves per cycle and `done` is asserted in the cycle after the `out_last` handshake.
- `busy` falls together with the `done` pulse. A new `start` is accepted in that same cycle.
- Outputs other than the ACCUM pass-through buses are registered or pure state decodes.

## Test plan
- Reset: hold `rst` 2 cycles with random inputs → every output matches its reset value. `start` during `rst` → ignored.
- Basic job: all weight codes 01, `step_vec`={0x02,0x01} on 7 back-to-back steps → seven bytes 0x15, `out_last` on the 7th, `done` one cycle later, 21 cycles total with `out_ready`=1.
- Signs/wrap: byte-0 codes 11, byte-1 codes 00 or 10, byte 0 = 0x05 → every output 0xDD (−35). Then codes 01 with 0x7F on both bytes → 0xF2 (1778 mod 256).
- Input stall: drop `step_valid` for 5 cycles after step 0 and for 3 cycles after step 4 → `mult_w`=0 during the gaps, `mult_row` holds the next index, results identical to the basic job.
- Output backpressure: random `out_ready` (50%) with distinct per-column weights → seven bytes in index order, none lost or duplicated, `out_data` stable while stalled.
- Control corners:
  - `start` pulsed in ACCUM and STREAM → ignored.
  - `rst` after 3 accepted steps → IDLE next cycle; the next full job produces correct results.
  - `start` in the `done` cycle → `step_ready` high in the following cycle.

Source files
------------

// File: rtl/ternary_mvm_seq.sv
// Step sequencer and result streamer for the 14x7 ternary matrix-vector datapath.
//
// state  | meaning
// IDLE   | waiting for start; datapath buses parked at zero, mult_row = 0
// ACCUM  | accepting one step per handshake; mult_row = k, buses pass through
// DRAIN  | walking mult_row = j across the datapath results into res_buf
// STREAM | presenting res_buf[p] on the output handshake
module ternary_mvm_seq #(
    parameter int InLen    = 14,
    parameter int OutLen   = 7,
    parameter int BitWidth = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    input  logic [2*InLen-1:0]    step_w,
    input  logic [2*BitWidth-1:0] step_vec,
    input  logic                  step_valid,
    output logic                  step_ready,
    output logic [2:0]            mult_row,
    output logic                  mult_en,
    output logic [2*InLen-1:0]    mult_w,
    output logic [2*BitWidth-1:0] mult_vec,
    input  logic [BitWidth-1:0]   mult_vecout,
    output logic [BitWidth-1:0]   out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  out_last
);

    localparam int         Steps    = InLen / 2;
    localparam logic [2:0] LastStep = 3'(Steps - 1);
    localparam logic [2:0] LastOut  = 3'(OutLen - 1);

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        DRAIN,
        STREAM
    } state_t;

    state_t              state;
    logic [2:0]          k;
    logic [2:0]          j;
    logic [2:0]          p;
    logic                done_q;
    logic [BitWidth-1:0] res_buf [OutLen];

    // Sequencing FSM: step counting, result collection, output indexing and done pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            k      <= '0;
            j      <= '0;
            p      <= '0;
            done_q <= 1'b0;
            for (int i = 0; i < OutLen; i++) begin
                res_buf[i] <= '0;
            end
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state <= ACCUM;
                        k     <= '0;
                    end
                end
                ACCUM: begin
                    if (step_valid) begin
                        k <= k + 3'd1;
                        if (k == LastStep) begin
                            state <= DRAIN;
                            j     <= '0;
                        end
                    end
                end
                DRAIN: begin
                    // The j = 0 cycle also makes the datapath latch its final sums.
                    res_buf[j] <= mult_vecout;
                    if (j == LastOut) begin
                        state <= STREAM;
                        p     <= '0;
                    end else begin
                        j <= j + 3'd1;
                    end
                end
                STREAM: begin
                    if (out_ready) begin
                        if (p == LastOut) begin
                            state  <= IDLE;
                            done_q <= 1'b1;
                        end else begin
                            p <= p + 3'd1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Datapath index follows the active counter; parked at 0 when idle or streaming.
    always_comb begin
        mult_row = 3'd0;
        case (state)
            ACCUM:   mult_row = k;
            DRAIN:   mult_row = j;
            default: mult_row = 3'd0;
        endcase
    end

    // Zero-latency step pass-through; zero buses add nothing to the accumulator.
    always_comb begin
        mult_w   = '0;
        mult_vec = '0;
        if (state == ACCUM && step_valid) begin
            mult_w   = step_w;
            mult_vec = step_vec;
        end
    end

    assign busy       = (state != IDLE);
    assign mult_en    = busy;
    assign done       = done_q;
    assign step_ready = (state == ACCUM);
    assign out_valid  = (state == STREAM);
    assign out_last   = out_valid && (p == LastOut);
    assign out_data   = out_valid ? res_buf[p] : '0;

endmodule

// File: tb/tb_ternary_mvm_seq.sv
// Self-checking bench for ternary_mvm_seq with a behavioural datapath and result model.
module tb_ternary_mvm_seq;

    localparam int InLen  = 14;
    localparam int OutLen = 7;
    localparam int BW     = 8;
    localparam int Steps  = InLen / 2;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              start = 1'b0;
    logic              busy, done;
    logic [2*InLen-1:0] step_w = '0;
    logic [2*BW-1:0]   step_vec = '0;
    logic              step_valid = 1'b0;
    logic              step_ready;
    logic [2:0]        mult_row;
    logic              mult_en;
    logic [2*InLen-1:0] mult_w;
    logic [2*BW-1:0]   mult_vec;
    logic [BW-1:0]     mult_vecout;
    logic [BW-1:0]     out_data;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic              out_last;

    int n_pass  = 0;
    int n_total = 0;

    logic [2*InLen-1:0] job_w   [Steps];
    logic [2*BW-1:0]    job_vec [Steps];
    logic [BW-1:0]      exp_res [OutLen];

    ternary_mvm_seq #(.InLen(InLen), .OutLen(OutLen), .BitWidth(BW)) dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
        .step_w(step_w), .step_vec(step_vec), .step_valid(step_valid),
        .step_ready(step_ready), .mult_row(mult_row), .mult_en(mult_en),
        .mult_w(mult_w), .mult_vec(mult_vec), .mult_vecout(mult_vecout),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_last(out_last)
    );

    always #5 clk = ~clk;

    function automatic int wv(input logic [1:0] code);
        case (code)
            2'b01:   return 1;
            2'b11:   return -1;
            default: return 0;
        endcase
    endfunction

    function automatic logic [BW-1:0] dp_contrib(input logic [2*InLen-1:0] w,
                                                  input logic [2*BW-1:0] v, input int c);
        int s;
        s = wv(w[2*c +: 2]) * int'($signed(v[BW-1:0]))
          + wv(w[InLen+2*c +: 2]) * int'($signed(v[2*BW-1:BW]));
        return s[BW-1:0];
    endfunction

    // Datapath model: reload at index 0, accumulate otherwise; result register
    // captures at index 0 and reading index 0 shows the byte being captured.
    logic [BW-1:0] dp_acc [OutLen] = '{default: 8'h00};
    logic [BW-1:0] dp_res [OutLen] = '{default: 8'h00};

    always @(posedge clk) begin
        for (int c = 0; c < OutLen; c++) begin
            if (mult_row == 3'd0) begin
                dp_res[c] <= dp_acc[c];
                dp_acc[c] <= dp_contrib(mult_w, mult_vec, c);
            end else begin
                dp_acc[c] <= dp_acc[c] + dp_contrib(mult_w, mult_vec, c);
            end
        end
    end

    assign mult_vecout = (mult_row == 3'd0) ? dp_acc[0] :
                         (int'(mult_row) < OutLen) ? dp_res[mult_row] : 8'h00;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_total++;
        assert (obs === expv) n_pass++;
        else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
    endtask

    // Reference: whole-job signed sum per output, reduced modulo 2^BW.
    task automatic compute_expected();
        for (int c = 0; c < OutLen; c++) begin
            int tot;
            tot = 0;
            for (int s = 0; s < Steps; s++) begin
                tot += wv(job_w[s][2*c +: 2]) * int'($signed(job_vec[s][BW-1:0]));
                tot += wv(job_w[s][InLen+2*c +: 2]) * int'($signed(job_vec[s][2*BW-1:BW]));
            end
            exp_res[c] = tot[BW-1:0];
        end
    endtask

    task automatic fill_random();
        for (int s = 0; s < Steps; s++) begin
            job_w[s]   = 28'($urandom);
            job_vec[s] = 16'($urandom);
        end
    endtask

    task automatic issue_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Runs one job from the first ACCUM cycle through the done pulse.
    task automatic do_job(input int gap0, input int gap4, input bit rand_ready,
                          input bit poke_start, input bit start_next, input string tag);
        int cyc;
        int idx;
        int g;
        bit stalled;
        logic [BW-1:0] stall_data;
        cyc = 1;
        compute_expected();
        #1;
        chk({tag, "_step_ready"}, step_ready, 1);
        for (int s = 0; s < Steps; s++) begin
            step_valid = 1'b1;
            step_w     = job_w[s];
            step_vec   = job_vec[s];
            if (poke_start && s == 2) start = 1'b1;
            #1;
            chk({tag, "_row"}, mult_row, s);
            chk({tag, "_pass_w"}, mult_w, job_w[s]);
            @(negedge clk);
            cyc++;
            start = 1'b0;
            g = (s == 0) ? gap0 : ((s == 4) ? gap4 : 0);
            for (int i = 0; i < g; i++) begin
                step_valid = 1'b0;
                step_w     = 28'($urandom);
                step_vec   = 16'($urandom);
                #1;
                chk({tag, "_gap_w"}, mult_w, 0);
                chk({tag, "_gap_vec"}, mult_vec, 0);
                chk({tag, "_gap_row"}, mult_row, s + 1);
                @(negedge clk);
                cyc++;
            end
        end
        step_valid = 1'b0;
        for (int b = 0; b < 40 && !out_valid; b++) begin
            @(negedge clk);
            cyc++;
        end
        chk({tag, "_first_valid"}, out_valid, 1);
        chk({tag, "_first_valid_cycle"}, cyc, Steps + OutLen + 1 + gap0 + gap4);
        idx = 0;
        stalled = 1'b0;
        stall_data = '0;
        for (int b = 0; b < 400 && idx < OutLen; b++) begin
            out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            if (poke_start && b == 1) start = 1'b1;
            #1;
            if (stalled) chk({tag, "_stall_hold"}, out_data, stall_data);
            if (out_ready) begin
                chk({tag, "_valid"}, out_valid, 1);
                chk({tag, "_data"}, out_data, exp_res[idx]);
                chk({tag, "_last"}, out_last, (idx == OutLen - 1));
                idx++;
                stalled = 1'b0;
            end else begin
                stalled    = 1'b1;
                stall_data = out_data;
            end
            @(negedge clk);
            cyc++;
            start = 1'b0;
        end
        out_ready = 1'b0;
        chk({tag, "_byte_count"}, idx, OutLen);
        if (!rand_ready) chk({tag, "_done_cycle"}, cyc, Steps + 2*OutLen + 1 + gap0 + gap4);
        chk({tag, "_done"}, done, 1);
        chk({tag, "_busy_low"}, busy, 0);
        if (start_next) begin
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
        end else begin
            @(negedge clk);
            chk({tag, "_done_pulse"}, done, 0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset with random inputs and start held high
        rst        = 1'b1;
        start      = 1'b1;
        step_valid = 1'b1;
        step_w     = 28'($urandom);
        step_vec   = 16'($urandom);
        out_ready  = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_step_ready", step_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_last", out_last, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_mult_row", mult_row, 0);
        chk("rst_mult_en", mult_en, 0);
        chk("rst_mult_w", mult_w, 0);
        chk("rst_mult_vec", mult_vec, 0);
        rst        = 1'b0;
        start      = 1'b0;
        step_valid = 1'b0;
        out_ready  = 1'b0;
        @(negedge clk);
        chk("rst_start_ignored", busy, 0);

        // Basic job: all +1, bytes 0x01 and 0x02
        for (int s = 0; s < Steps; s++) begin
            job_w[s]   = 28'h5555555;
            job_vec[s] = 16'h0201;
        end
        issue_start();
        do_job(0, 0, 1'b0, 1'b0, 1'b0, "basic");

        // Negative weights on byte 0, zero codes on byte 1
        for (int s = 0; s < Steps; s++) begin
            logic [2*InLen-1:0] w;
            w = '0;
            for (int c = 0; c < OutLen; c++) begin
                w[2*c +: 2]       = 2'b11;
                w[InLen+2*c +: 2] = {1'($urandom_range(0, 1)), 1'b0};
            end
            job_w[s]   = w;
            job_vec[s] = {8'($urandom), 8'h05};
        end
        issue_start();
        do_job(0, 0, 1'b0, 1'b0, 1'b0, "signs");

        // Wrap: 7 * (127 + 127)
        for (int s = 0; s < Steps; s++) begin
            job_w[s]   = 28'h5555555;
            job_vec[s] = 16'h7F7F;
        end
        issue_start();
        do_job(0, 0, 1'b0, 1'b0, 1'b0, "wrap");

        // Input stalls after steps 0 and 4
        for (int s = 0; s < Steps; s++) begin
            job_w[s]   = 28'h5555555;
            job_vec[s] = 16'h0201;
        end
        issue_start();
        do_job(5, 3, 1'b0, 1'b0, 1'b0, "stall");

        // Output backpressure with distinct per-column weights
        fill_random();
        issue_start();
        do_job(0, 0, 1'b1, 1'b0, 1'b0, "bpress");

        // start pulsed in ACCUM and STREAM, then start in the done cycle
        fill_random();
        issue_start();
        do_job(0, 0, 1'b0, 1'b1, 1'b1, "poke");
        fill_random();
        do_job(0, 0, 1'b0, 1'b0, 1'b0, "chained");

        // Reset after three accepted steps
        fill_random();
        issue_start();
        for (int s = 0; s < 3; s++) begin
            step_valid = 1'b1;
            step_w     = job_w[s];
            step_vec   = job_vec[s];
            @(negedge clk);
        end
        step_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_busy", busy, 0);
        chk("midrst_step_ready", step_ready, 0);
        chk("midrst_row", mult_row, 0);
        fill_random();
        issue_start();
        do_job(0, 0, 1'b1, 1'b0, 1'b0, "after_rst");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
